mem_bus_arbiter: RTL

- Shares the single-port 64 KB system memory between two requesters: the CPU core (port C) and a DMA/loader engine (port D).
- Selects one requester per cycle and drives the memory's address, write-data and write-enable inputs combinationally from the winner.
- Routes the memory's registered read data back with a one-cycle valid strobe.
- Provides round-robin fairness, plus a DMA burst-lock mode with a bounded CPU starvation window.

---
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between a CPU port (c_*) and a
// DMA/loader port (d_*).
//
// Arbitration:
// - Round-robin in StArb.
// - Optional DMA burst lock in StLock.
// - Under lock, one forced CPU slot is granted after MAX_BURST locked DMA grants.
//
// Datapath:
// - Grants and memory-side signals are combinational from the winning port.
// - Read-valid strobes are registered one cycle after a read grant.
// - Read data passes straight through from mem_data_out_i.
//
// Ports:
//   clk_i, reset_i                  clock, async active-high reset
//   c_req_i/c_we_i/c_addr_i/c_wdata_i    CPU request
//   c_gnt_o, c_rvalid_o, c_rdata_o       CPU grant and read return
//   d_req_i/d_we_i/d_addr_i/d_wdata_i    DMA request
//   d_lock_i                             DMA burst-lock request
//   d_gnt_o, d_rvalid_o, d_rdata_o       DMA grant and read return
//   mem_address_o, mem_data_in_o, mem_write_o   to memory
//   mem_data_out_i                       registered read data from memory
//
// Optional build macro MEM_ARB_PERF_EN adds two saturating 16-bit counters:
//   c_stall_cnt_o   cycles with the CPU requesting but not granted
//   d_grant_cnt_o   DMA grants
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned RESET_OWNER = 0
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [DATA_W-1:0] c_wdata_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [DATA_W-1:0] c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  input  logic              d_lock_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_data_out_i
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]       c_stall_cnt_o,
  output logic [15:0]       d_grant_cnt_o
`endif
);

  localparam logic [7:0] MaxBurst = 8'(MAX_BURST);

  typedef enum logic {StArb, StLock} state_e;

  state_e      state_q, state_d;
  logic        last_owner_q, last_owner_d;  // 0 = CPU, 1 = DMA
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic        c_rvalid_q, d_rvalid_q;
  logic        c_win, d_win;

  always_comb begin
    c_win       = 1'b0;
    d_win       = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      StArb: begin
        if (c_req_i && d_req_i) begin
          // Both requesting: the port that did not win last time gets the slot.
          c_win = last_owner_q;
          d_win = ~last_owner_q;
        end else begin
          c_win = c_req_i;
          d_win = d_req_i;
        end
        if (d_win && d_lock_i) begin
          state_d     = StLock;
          burst_cnt_d = 8'd1;
        end
      end
      StLock: begin
        if (d_req_i) begin
          if (burst_cnt_q < MaxBurst) begin
            d_win       = 1'b1;
            burst_cnt_d = burst_cnt_q + 8'd1;
          end else if (c_req_i) begin
            // Forced CPU slot bounds CPU starvation during a long burst.
            c_win       = 1'b1;
            burst_cnt_d = '0;
          end else begin
            d_win = 1'b1;
          end
        end else begin
          c_win = c_req_i;
        end
        // The lock is dropped at the edge where d_lock is sampled low,
        // regardless of whether DMA wins in this cycle.
        if (!d_lock_i) begin
          state_d     = StArb;
          burst_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Reset blanks the grants combinationally, so the memory side sees nothing while it is high.
  assign c_gnt_o = c_win & ~reset_i;
  assign d_gnt_o = d_win & ~reset_i;

  always_comb begin
    last_owner_d = last_owner_q;
    if (c_gnt_o) begin
      last_owner_d = 1'b0;
    end else if (d_gnt_o) begin
      last_owner_d = 1'b1;
    end
  end

  always_comb begin
    mem_address_o = '0;
    mem_data_in_o = '0;
    mem_write_o   = 1'b0;
    if (c_gnt_o) begin
      mem_address_o = c_addr_i;
      mem_data_in_o = c_wdata_i;
      mem_write_o   = c_we_i;
    end else if (d_gnt_o) begin
      mem_address_o = d_addr_i;
      mem_data_in_o = d_wdata_i;
      mem_write_o   = d_we_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StArb;
      last_owner_q <= (RESET_OWNER != 0);
      burst_cnt_q  <= '0;
      c_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      c_rvalid_q   <= c_gnt_o & ~c_we_i;
      d_rvalid_q   <= d_gnt_o & ~d_we_i;
    end
  end

  assign c_rvalid_o = c_rvalid_q;
  assign d_rvalid_o = d_rvalid_q;
  assign c_rdata_o  = mem_data_out_i;
  assign d_rdata_o  = mem_data_out_i;

`ifdef MEM_ARB_PERF_EN
  logic [15:0] c_stall_cnt_q, d_grant_cnt_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      c_stall_cnt_q <= '0;
      d_grant_cnt_q <= '0;
    end else begin
      if (c_req_i && !c_gnt_o && (c_stall_cnt_q != 16'hFFFF)) begin
        c_stall_cnt_q <= c_stall_cnt_q + 16'd1;
      end
      if (d_gnt_o && (d_grant_cnt_q != 16'hFFFF)) begin
        d_grant_cnt_q <= d_grant_cnt_q + 16'd1;
      end
    end
  end

  assign c_stall_cnt_o = c_stall_cnt_q;
  assign d_grant_cnt_o = d_grant_cnt_q;
`endif

endmodule
